// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder/subtractor.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-pass adder still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_adder_chunk_ripple.sv
// Combinational CHUNK-bit ripple-carry chain; also exposes the carry into the top bit.
module chunk_ripple #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic carry_c;

  always_comb begin
    carry_c  = cin;
    c_msb_in = cin;
    s        = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) c_msb_in = carry_c;
      s[i]    = a[i] ^ b[i] ^ carry_c;
      carry_c = (a[i] & b[i]) | (carry_c & (a[i] ^ b[i]));
    end
    cout = carry_c;
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple stage reused WIDTH/CHUNK times
// behind valid/ready handshakes, with carry held in a register between chunks.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int unsigned IDX_W      = idx_w(NUM_CHUNKS);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder: WIDTH must be a positive integer multiple of CHUNK");
  end

  state_e           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK-1:0] s_chunk_c;
  logic             cout_c;
  logic             c_msb_c;
  logic             last_c;

  // Select the operand slices for the chunk currently being processed.
  always_comb begin
    a_chunk_c = op_a[32'(idx) * CHUNK +: CHUNK];
    b_chunk_c = op_b[32'(idx) * CHUNK +: CHUNK];
    last_c    = (idx == IDX_W'(NUM_CHUNKS - 1));
  end

  chunk_ripple #(
    .CHUNK(CHUNK)
  ) u_ripple (
    .a        (a_chunk_c),
    .b        (b_chunk_c),
    .cin      (carry),
    .s        (s_chunk_c),
    .cout     (cout_c),
    .c_msb_in (c_msb_c)
  );

  // Control FSM and datapath registers; subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[32'(idx) * CHUNK +: CHUNK] <= s_chunk_c;
          carry <= cout_c;
          idx   <= idx + IDX_W'(1);
          if (last_c) begin
            sum[WIDTH] <= cout_c;
            ovf        <= c_msb_c ^ cout_c;
            idx        <= '0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder at CHUNK = 4 (directed), 1 and 16 (random sweep).
module tb_chunked_adder;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic             in_valid_v  [3];
  logic             in_ready_v  [3];
  logic [WIDTH-1:0] a_v         [3];
  logic [WIDTH-1:0] b_v         [3];
  logic             sub_v       [3];
  logic             out_valid_v [3];
  logic             out_ready_v [3];
  logic [WIDTH:0]   sum_v       [3];
  logic             ovf_v       [3];

  int   lat_exp [3] = '{4, 16, 1};
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum_v[0]), .ovf(ovf_v[0])
  );

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum_v[1]), .ovf(ovf_v[1])
  );

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .sum(sum_v[2]), .ovf(ovf_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    bb    = s ? ~b : b;
    e.sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
    e.ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one operation for exactly one edge.
  task automatic accept(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s);
    int n = 0;
    while (!in_ready_v[k] && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready_v[k]) check("in_ready_timeout", 32'(in_ready_v[k]), 32'd1);
    in_valid_v[k] = 1'b1;
    a_v[k]        = a;
    b_v[k]        = b;
    sub_v[k]      = s;
    tick();
    in_valid_v[k] = 1'b0;
  endtask

  // Full transaction: push expectation, measure latency and busy window, optional backpressure.
  task automatic do_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input int hold);
    exp_t e;
    int   lat = 0;
    int   low = 0;
    sb.push_back(model(a, b, s));
    accept(k, a, b, s);
    if (!in_ready_v[k]) low++;
    while (!out_valid_v[k] && lat < 40) begin
      tick();
      lat++;
      if (!in_ready_v[k]) low++;
    end
    if (!out_valid_v[k]) begin
      check("out_valid_timeout", 32'(out_valid_v[k]), 32'd1);
      sb.delete();
      return;
    end
    check("latency", 32'(lat), 32'(lat_exp[k]));
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("sum", 32'(sum_v[k]), 32'(e.sum));
    check("ovf", 32'(ovf_v[k]), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid_v[k] = 1'b1;
      a_v[k]        = WIDTH'($urandom);
      b_v[k]        = WIDTH'($urandom);
      sub_v[k]      = 1'($urandom);
      tick();
      check("hold_sum", 32'(sum_v[k]), 32'(e.sum));
      check("hold_ovf", 32'(ovf_v[k]), 32'(e.ovf));
      check("hold_in_ready", 32'(in_ready_v[k]), 32'd0);
      check("hold_out_valid", 32'(out_valid_v[k]), 32'd1);
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    check("busy_cycles", 32'(low), 32'(lat_exp[k] + 1));
    check("post_out_valid", 32'(out_valid_v[k]), 32'd0);
    check("post_in_ready", 32'(in_ready_v[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k]  = 1'b0;
      a_v[k]         = '0;
      b_v[k]         = '0;
      sub_v[k]       = 1'b0;
      out_ready_v[k] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready_v[0]), 32'd0);
    check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("rst_sum", 32'(sum_v[0]), 32'd0);
    check("rst_ovf", 32'(ovf_v[0]), 32'd0);
    rst = 1'b0;
    tick();
    check("first_in_ready", 32'(in_ready_v[0]), 32'd1);

    do_op(0, 16'd6,      16'd14,     1'b0, 0);
    do_op(0, 16'hFFFF,   16'h0001,   1'b0, 0);
    do_op(0, 16'h7FFF,   16'h0001,   1'b0, 0);
    do_op(0, 16'h0005,   16'h0007,   1'b1, 0);
    do_op(0, 16'h8000,   16'h0001,   1'b1, 0);
    do_op(0, 16'h1234,   16'h4321,   1'b0, 3);

    // Only one result after backpressure: nothing further appears.
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_extra_result", 32'(out_valid_v[0]), 32'd0);
    end

    // Reset pulse in the second RUN cycle drops the operation.
    accept(0, 16'h1234, 16'h0FF1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrun_sum", 32'(sum_v[0]), 32'd0);
    check("midrun_in_ready", 32'(in_ready_v[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrun_quiet", 32'(out_valid_v[0]), 32'd0);
    end
    do_op(0, 16'd1, 16'd1, 1'b0, 0);

    // Random sweep over all three chunk sizes, plus corner operands.
    for (int k = 0; k < 3; k++) begin
      do_op(k, 16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(k, 16'h8000, 16'h0001, 1'b1, 0);
      for (int i = 0; i < 12; i++) begin
        do_op(k, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (i == 5) ? 1 : 0);
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
